// File: rtl/sram_responder_if.sv
// LC-3 active-low SRAM strobe bus between the CPU side (master) and the memory responder (slave).
// The shared I_O bus is resolved here from the two tri-state drivers.
interface sram_responder_if;
  logic [19:0] A;
  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  wire  [15:0] I_O;
  logic        R;

  // responder-side read drive and CPU-side write drive
  logic [15:0] rd_data;
  logic        rd_oe;
  logic [15:0] wr_data;
  logic        wr_oe;

  assign I_O = rd_oe ? rd_data : 'z;
  assign I_O = wr_oe ? wr_data : 'z;

  modport slave (
    input  A, CE, UB, LB, OE, WE, I_O,
    output R, rd_data, rd_oe
  );

  modport master (
    output A, CE, UB, LB, OE, WE, wr_data, wr_oe,
    input  I_O, R, rd_oe
  );
endinterface

// File: rtl/sram_responder.sv
// Memory-side responder for the LC-3 SRAM strobe interface: serves reads/writes from an
// internal word array after programmable wait states and pulses R when an access completes.
module sram_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_responder_if.slave   bus
);

  localparam int DEPTH    = 2 ** DEPTH_LOG2;
  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_DONE = 3'd2,
    WR_WAIT = 3'd3,
    WR_DONE = 3'd4,
    HOLD    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [1:0]            lane_q, lane_d;     // [1] = upper byte enabled, [0] = lower
  logic                  is_read_q, is_read_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  wr_commit;

  logic                  start_wr, start_rd, rd_release, wr_release, hold_exit;

  logic [15:0]           mem [DEPTH];

  // WE low takes precedence over OE low when both are asserted
  always_comb begin
    start_wr   = !bus.CE && !bus.WE;
    start_rd   = !bus.CE && !bus.OE && bus.WE;
    rd_release = bus.CE || bus.OE;
    wr_release = bus.CE || bus.WE;
    hold_exit  = bus.CE || (bus.OE && bus.WE);
  end

  // Next-state and datapath capture
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    lane_d    = lane_q;
    is_read_d = is_read_q;

    case (state_q)
      IDLE: begin
        if (start_wr) begin
          addr_d    = bus.A[DEPTH_LOG2-1:0];
          lane_d    = {~bus.UB, ~bus.LB};
          is_read_d = 1'b0;
          cnt_d     = WR_LOAD;
          state_d   = (WRITE_WAIT == 0) ? WR_DONE : WR_WAIT;
        end else if (start_rd) begin
          addr_d    = bus.A[DEPTH_LOG2-1:0];
          lane_d    = {~bus.UB, ~bus.LB};
          is_read_d = 1'b1;
          cnt_d     = RD_LOAD;
          state_d   = (READ_WAIT == 0) ? RD_DONE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_release) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = RD_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      WR_WAIT: begin
        if (wr_release) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = WR_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      RD_DONE, WR_DONE: state_d = HOLD;
      HOLD:             if (hold_exit) state_d = IDLE;
      default:          state_d = IDLE;
    endcase

    // DONE states last one cycle, so state_d == *_DONE marks the entry edge
    wr_commit = (state_d == WR_DONE);
    rdata_d   = rdata_q;
    if (state_d == RD_DONE) begin
      rdata_d = {lane_d[1] ? mem[addr_d][15:8] : 8'h00,
                 lane_d[0] ? mem[addr_d][7:0]  : 8'h00};
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    bus.R       = (state_q == RD_DONE) || (state_q == WR_DONE);
    bus.rd_data = rdata_q;
    bus.rd_oe   = is_read_q && ((state_q == RD_DONE) || (state_q == HOLD)) &&
                  !bus.CE && !bus.OE && bus.WE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      lane_q    <= '0;
      is_read_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      is_read_q <= is_read_d;
      rdata_q   <= rdata_d;
    end
  end

  // NOTE: the array has no reset; contents survive Reset and only enabled lanes are written.
  always_ff @(posedge Clk) begin
    if (!Reset && wr_commit) begin
      if (lane_d[1]) mem[addr_d][15:8] <= bus.I_O[15:8];
      if (lane_d[0]) mem[addr_d][7:0]  <= bus.I_O[7:0];
    end
  end

endmodule
